// File: rtl/reg_scoreboard_if.sv
// Decode/issue/retire bus of the register scoreboard.
// The bench drives it as master and the scoreboard consumes it as slave.
interface reg_scoreboard_if #(
    parameter int TOT_W = 4,
    parameter int IDX_W = 5
);
    logic             issue_valid;
    logic             issue_wr_en;
    logic             issue_is_load;
    logic [IDX_W-1:0] issue_rd;
    logic             load_done_valid;
    logic [IDX_W-1:0] load_done_rd;
    logic             retire_valid;
    logic             retire_wr_en;
    logic [IDX_W-1:0] retire_rd;
    logic             flush;
    logic [IDX_W-1:0] rs1_idx;
    logic [IDX_W-1:0] rs2_idx;
    logic             rs1_used;
    logic             rs2_used;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rs1_load_pending;
    logic             rs2_load_pending;
    logic             load_use_stall;
    logic [TOT_W-1:0] inflight_total;
    logic             err_overflow;
    logic             err_underflow;

    modport master (
        output issue_valid, issue_wr_en, issue_is_load, issue_rd,
               load_done_valid, load_done_rd,
               retire_valid, retire_wr_en, retire_rd, flush,
               rs1_idx, rs2_idx, rs1_used, rs2_used,
        input  rs1_busy, rs2_busy, rs1_load_pending, rs2_load_pending,
               load_use_stall, inflight_total, err_overflow, err_underflow
    );

    modport slave (
        input  issue_valid, issue_wr_en, issue_is_load, issue_rd,
               load_done_valid, load_done_rd,
               retire_valid, retire_wr_en, retire_rd, flush,
               rs1_idx, rs2_idx, rs1_used, rs2_used,
        output rs1_busy, rs2_busy, rs1_load_pending, rs2_load_pending,
               load_use_stall, inflight_total, err_overflow, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write / pending-load counters feeding the decode
// load-use stall, plus a saturating in-flight total and sticky error flags.
module reg_scoreboard_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf,
    output logic         o_unf
);
    logic [W-1:0] r_cnt;
    logic         w_up;
    logic         w_dn;

    // Simultaneous inc and dec cancel, so they can never raise an error.
    assign w_up  = i_inc & ~i_dec;
    assign w_dn  = i_dec & ~i_inc;
    assign o_ovf = w_up & (r_cnt == {W{1'b1}});
    assign o_unf = w_dn & (r_cnt == '0);
    assign o_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (w_up && !o_ovf)
            r_cnt <= r_cnt + 1'b1;
        else if (w_dn && !o_unf)
            r_cnt <= r_cnt - 1'b1;
    end
endmodule

module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 3,
    parameter int TOT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  bus
);
    localparam int IDX_W = $clog2(NREG);

    logic             w_iss;
    logic             w_iss_ld;
    logic             w_ldd;
    logic             w_ret;
    logic [NREG-1:0]  w_busy_nz;
    logic [NREG-1:0]  w_load_nz;
    logic [NREG-1:0]  w_ovf_vec;
    logic [NREG-1:0]  w_unf_vec;
    logic [TOT_W-1:0] w_tot;
    logic             w_tot_ovf;
    logic             w_tot_unf;
    logic             r_err_ovf;
    logic             r_err_unf;

    // Flush masks every event so discarded traffic cannot trip the error flags.
    assign w_iss    = bus.issue_valid & bus.issue_wr_en & (bus.issue_rd != '0) & ~bus.flush;
    assign w_iss_ld = w_iss & bus.issue_is_load;
    assign w_ldd    = bus.load_done_valid & (bus.load_done_rd != '0) & ~bus.flush;
    assign w_ret    = bus.retire_valid & bus.retire_wr_en & (bus.retire_rd != '0) & ~bus.flush;

    assign w_busy_nz[0] = 1'b0;
    assign w_load_nz[0] = 1'b0;
    assign w_ovf_vec[0] = 1'b0;
    assign w_unf_vec[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [CNT_W-1:0] w_bcnt;
        logic [CNT_W-1:0] w_lcnt;
        logic             w_b_ovf, w_b_unf, w_l_ovf, w_l_unf;

        reg_scoreboard_cnt #(.W(CNT_W)) u_busy (
            .clk   (clk),
            .rst   (rst),
            .i_clr (bus.flush),
            .i_inc (w_iss && (bus.issue_rd == IDX_W'(r))),
            .i_dec (w_ret && (bus.retire_rd == IDX_W'(r))),
            .o_cnt (w_bcnt),
            .o_ovf (w_b_ovf),
            .o_unf (w_b_unf)
        );

        reg_scoreboard_cnt #(.W(CNT_W)) u_load (
            .clk   (clk),
            .rst   (rst),
            .i_clr (bus.flush),
            .i_inc (w_iss_ld && (bus.issue_rd == IDX_W'(r))),
            .i_dec (w_ldd && (bus.load_done_rd == IDX_W'(r))),
            .o_cnt (w_lcnt),
            .o_ovf (w_l_ovf),
            .o_unf (w_l_unf)
        );

        assign w_busy_nz[r] = |w_bcnt;
        assign w_load_nz[r] = |w_lcnt;
        assign w_ovf_vec[r] = w_b_ovf | w_l_ovf;
        assign w_unf_vec[r] = w_b_unf | w_l_unf;
    end

    reg_scoreboard_cnt #(.W(TOT_W)) u_tot (
        .clk   (clk),
        .rst   (rst),
        .i_clr (bus.flush),
        .i_inc (w_iss),
        .i_dec (w_ret),
        .o_cnt (w_tot),
        .o_ovf (w_tot_ovf),
        .o_unf (w_tot_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_err_ovf <= r_err_ovf | (|w_ovf_vec) | w_tot_ovf;
            r_err_unf <= r_err_unf | (|w_unf_vec) | w_tot_unf;
        end
    end

    assign bus.rs1_busy         = w_busy_nz[bus.rs1_idx];
    assign bus.rs2_busy         = w_busy_nz[bus.rs2_idx];
    assign bus.rs1_load_pending = w_load_nz[bus.rs1_idx];
    assign bus.rs2_load_pending = w_load_nz[bus.rs2_idx];
    assign bus.load_use_stall   = (bus.rs1_used & bus.rs1_load_pending) |
                                  (bus.rs2_used & bus.rs2_load_pending);
    assign bus.inflight_total   = w_tot;
    assign bus.err_overflow     = r_err_ovf;
    assign bus.err_underflow    = r_err_unf;
endmodule
